// File: rtl/aes_out_collector_pkg.sv
// Shared AES widths and the round constant that marks the last AES-128 round.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int RCON_W      = 8;
  localparam logic [RCON_W-1:0] FINAL_RCON_AES128 = 8'h36;
endpackage

// File: rtl/aes_out_collector_if.sv
// Block-input and ciphertext-output signals between the AES pipeline end and its consumer.
interface aes_out_collector_if #(
  parameter int DEPTH = 4
);
  logic [aes_pkg::AES_BLOCK_W-1:0] in;
  logic [aes_pkg::RCON_W-1:0]      Rcon_in;
  logic                            in_valid;
  logic [aes_pkg::AES_BLOCK_W-1:0] out;
  logic                            out_valid;
  logic                            out_ready;
  logic [$clog2(DEPTH+1)-1:0]      count;
  logic                            overflow;

  modport master (
    output in, Rcon_in, in_valid, out_ready,
    input  out, out_valid, count, overflow
  );

  modport slave (
    input  in, Rcon_in, in_valid, out_ready,
    output out, out_valid, count, overflow
  );
endinterface

// File: rtl/aes_out_collector.sv
// Collects blocks leaving the last AES round into a small FIFO; non-final rounds are ignored
// and a final block arriving while full is dropped and latched into a sticky overflow flag.
module aes_out_collector
  import aes_pkg::*;
#(
  parameter int                DEPTH      = 4,
  parameter logic [RCON_W-1:0] FINAL_RCON = FINAL_RCON_AES128
) (
  input logic                clock,
  input logic                reset,
  aes_out_collector_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [AES_BLOCK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       cnt;
  logic                   ovf;

  logic push_req;
  logic pop;
  logic full;
  logic push;
  logic drop;

  always_comb begin
    push_req = bus.in_valid && (bus.Rcon_in == FINAL_RCON);
    pop      = (cnt != '0) && bus.out_ready;
    full     = (cnt == FULL_CNT);
    // A full FIFO still accepts a block in the same cycle its head leaves.
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // Storage is data only: reset discards entries by clearing the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.in;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Head is read through the registered pointer, so out never depends on in combinationally.
  always_comb begin
    bus.out_valid = (cnt != '0);
    bus.out       = bus.out_valid ? mem[rd_ptr] : '0;
    bus.count     = cnt;
    bus.overflow  = ovf;
  end

endmodule

// File: tb/tb_aes_out_collector.sv
// Randomised and directed stimulus against a queue-based reference of the output collector.
module tb_aes_out_collector;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [127:0] exp_q[$];
  logic         exp_ovf = 1'b0;

  aes_out_collector_if #(.DEPTH(DEPTH)) bus ();

  aes_out_collector #(.DEPTH(DEPTH)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a FIFO of at most DEPTH final blocks, updated with the values present at each edge.
  initial begin
    bit pop_m, fin, push_m;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        exp_ovf = 1'b0;
      end else begin
        fin    = bus.in_valid && (bus.Rcon_in == 8'h36);
        pop_m  = (exp_q.size() > 0) && bus.out_ready;
        push_m = fin && ((exp_q.size() < DEPTH) || pop_m);
        if (pop_m) void'(exp_q.pop_front());
        if (push_m) exp_q.push_back(bus.in);
        if (fin && !push_m) exp_ovf = 1'b1;
      end
    end
  end

  // Monitor: compares what the DUT presents midway between edges.
  initial begin
    forever begin
      @(negedge clk);
      check("out_valid", {127'b0, bus.out_valid}, {127'b0, exp_q.size() > 0});
      check("count", 128'(bus.count), 128'(exp_q.size()));
      check("overflow", {127'b0, bus.overflow}, {127'b0, exp_ovf});
      if (exp_q.size() > 0) check("out_head", bus.out, exp_q[0]);
      else                  check("out_empty", bus.out, 128'h0);
    end
  end

  task automatic cyc(input logic iv, input logic [7:0] rc, input logic [127:0] d, input logic rdy);
    bus.in_valid  = iv;
    bus.Rcon_in   = rc;
    bus.in        = d;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    cyc(1'b0, 8'h00, 128'h0, 1'b0);
    cyc(1'b0, 8'h00, 128'h0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] d;
    logic [7:0]   rc;
    bus.in_valid  = 1'b0;
    bus.Rcon_in   = 8'h00;
    bus.in        = '0;
    bus.out_ready = 1'b0;
    #1;
    check("reset_count", 128'(bus.count), 128'h0);
    check("reset_out_valid", {127'b0, bus.out_valid}, 128'h0);
    check("reset_out", bus.out, 128'h0);
    do_reset();

    // Single block through an empty FIFO.
    cyc(1'b1, 8'h36, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
    cyc(1'b0, 8'h00, 128'h0, 1'b1);
    cyc(1'b0, 8'h00, 128'h0, 1'b1);

    // Non-final round constants are ignored.
    cyc(1'b1, 8'h1b, 128'hdead, 1'b1);
    cyc(1'b1, 8'h80, 128'hbeef, 1'b1);
    cyc(1'b0, 8'h36, 128'hcafe, 1'b1);
    cyc(1'b0, 8'h00, 128'h0, 1'b1);

    // Full FIFO with a simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'h36, 128'(16 + i), 1'b0);
    cyc(1'b1, 8'h36, 128'hA, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 8'h00, 128'h0, 1'b1);

    // Pointer wrap with a toggling consumer.
    for (int i = 0; i < 20; i++) cyc(i % 2 == 0, 8'h36, 128'(32 + i), i % 2 == 1);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 8'h00, 128'h0, 1'b1);
    check("no_overflow_after_wrap", {127'b0, bus.overflow}, 128'h0);

    // Fill and overflow.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'h36, 128'(i), 1'b0);
    check("count_full", 128'(bus.count), 128'(DEPTH));
    check("overflow_set", {127'b0, bus.overflow}, 128'h1);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 8'h00, 128'h0, 1'b1);
    cyc(1'b1, 8'h36, 128'h77, 1'b1);
    cyc(1'b0, 8'h00, 128'h0, 1'b1);

    // Asynchronous reset between edges with entries buffered.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h36, 128'(64 + i), 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check("async_count", 128'(bus.count), 128'h0);
    check("async_out_valid", {127'b0, bus.out_valid}, 128'h0);
    check("async_out", bus.out, 128'h0);
    cyc(1'b1, 8'h36, 128'h99, 1'b1);
    rst = 1'b0;
    cyc(1'b1, 8'h36, 128'h1234_5678, 1'b0);
    cyc(1'b0, 8'h00, 128'h0, 1'b1);
    cyc(1'b0, 8'h00, 128'h0, 1'b1);

    // Randomised traffic: a mostly-ready phase then a mostly-stalled phase.
    for (int i = 0; i < 600; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0, 1:    rc = 8'h36;
        2:       rc = 8'h1b;
        default: rc = 8'($urandom_range(0, 255));
      endcase
      cyc($urandom_range(0, 2) != 0, rc, d,
          (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 8'h00, 128'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_out_collector.md
AES_OUT_COLLECTOR -- requirements
Module: aes_out_collector

Interface
REQ-001 Parameter DEPTH, default 4: number of 128-bit ciphertext entries buffered; power of two, at least 2.
REQ-002 Parameter FINAL_RCON, default 8'h36: Rcon value that marks a block as having completed its last round.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port in, input, 128: state word from the end-of-pipeline register.
REQ-006 Port Rcon_in, input, 8: round constant travelling with in.
REQ-007 Port in_valid, input, 1: in/Rcon_in carry a live block this cycle.
REQ-008 Port out, output, 128: ciphertext at the FIFO head.
REQ-009 Port out_valid, output, 1: out holds a valid ciphertext.
REQ-010 Port out_ready, input, 1: consumer accepts out this cycle.
REQ-011 Port count, output, $clog2(DEPTH+1): number of buffered entries.
REQ-012 Port overflow, output, 1: sticky flag meaning a final block was dropped.

Function
REQ-013 A push SHALL occur when in_valid=1 and Rcon_in==FINAL_RCON; all other input cycles SHALL be ignored.
REQ-014 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-015 A pushed block SHALL appear on out, with out_valid=1, on the first cycle after the push edge when the FIFO was empty (1-cycle latency).
REQ-016 Order SHALL be strict FIFO; out SHALL be stable while out_valid=1 and out_ready=0.
REQ-017 When empty: out_valid=0 and out=128'h0.
REQ-018 count SHALL change by +1 on push only, by -1 on pop only, and SHALL stay unchanged on simultaneous push+pop or when idle; range 0..DEPTH.
REQ-019 When full (count==DEPTH): a push with a simultaneous pop SHALL be accepted; a push without a pop SHALL be dropped, leave storage unchanged, and set overflow.
REQ-020 Simultaneous push and pop when empty SHALL NOT be possible, because out_valid=0; the push SHALL be accepted normally.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH without a bubble.
REQ-022 overflow SHALL remain 1 until reset; it SHALL NOT block further pushes once space exists.
REQ-023 There is no upstream backpressure; in SHALL be sampled without any ready signal.

Reset
REQ-024 Asserting reset SHALL clear pointers, count=0, out_valid=0, out=128'h0 and overflow=0 immediately, regardless of clock.
REQ-025 Reset mid-operation SHALL discard all buffered entries; storage contents need not be cleared.
REQ-026 While reset=1, pushes and pops SHALL have no effect; the first push SHALL be possible on the first rising clock edge after deassertion.

Structure
REQ-027 Package aes_pkg SHALL hold AES_BLOCK_W=128, RCON_W=8 and FINAL_RCON_AES128=8'h36; the FINAL_RCON parameter default SHALL take its value from the package.
REQ-028 The block SHALL be a single module with inline register-array storage and no sub-module.
REQ-029 out SHALL be driven from a registered head path (registered output or registered head pointer); there SHALL be no combinational path from in to out.

Verification
REQ-030 Single block: reset, then push in=128'h69c4e0d86a7b0430d8cdb78070b4c55a with Rcon_in=8'h36, out_ready=1 -> next cycle out_valid=1 and out equals that value; following cycle count=0.
REQ-031 Filter: in_valid=1 with Rcon_in=8'h1b, then 8'h80 -> no push; count=0 and out_valid=0 throughout.
REQ-032 Fill and overflow: out_ready=0, push 5 final blocks 128'h1..128'h5 -> count=4, overflow=1, pops return 1,2,3,4 and block 5 is absent.
REQ-033 Full with simultaneous push+pop: count=4, out_ready=1, push 128'hA -> count stays 4, head advances, 128'hA is delivered last, overflow=0.
REQ-034 Wrap: stream 10 final blocks with out_ready toggling 1/0 every cycle -> all 10 emerge in order with no loss and overflow=0.
REQ-035 Async reset: with 3 entries buffered, assert reset between clock edges -> out_valid=0, count=0 and out=0 without a clock edge; a new push afterwards emerges correctly.
